fifo_word_packer: RTL and testbench

- Downstream consumer of the word-wide operand FIFO. Pops WORDS consecutive words and assembles one wide big-number operand, LSW first, for the Paillier modular-arithmetic core.
- Presents the finished operand on a valid/ready interface and holds it stable until accepted.
- The FIFO is first-word-fall-through: read data equals the head word whenever the FIFO is non-empty, and asserting rd_en pops that word at the clock edge.

---
 rtl/fifo_word_packer.sv | 91 +++++++++
 tb/tb_fifo_word_packer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Pops WORDS consecutive words from a first-word-fall-through FIFO and assembles them,
// LSW first, into one wide operand presented on a valid/ready interface.
module fifo_word_packer #(
   parameter int unsigned WORD_WIDTH = 64,
   parameter int unsigned WORDS      = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   output logic                          fifo_rd_en,
   input  logic [WORD_WIDTH-1:0]         fifo_rd_data,
   input  logic                          fifo_rd_empty,
   output logic                          op_valid,
   input  logic                          op_ready,
   output logic [WORD_WIDTH*WORDS-1:0]   op_data,
   output logic [$clog2(WORDS):0]        op_word_cnt
);

   localparam int unsigned CntW = $clog2(WORDS) + 1;

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e                      state_q, state_d;
   logic                        valid_q, valid_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [WORD_WIDTH*WORDS-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StFill;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // rst gates the pop so the FIFO is never drained while the packer is held in reset.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      fifo_rd_en = 1'b0;
      if (clr) begin
         state_d = StFill;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (!fifo_rd_empty && !rst) begin
                  fifo_rd_en = 1'b1;
                  cnt_d      = cnt_q + CntW'(1);
                  if (cnt_q == CntW'(WORDS - 1)) begin
                     state_d = StHold;
                     valid_d = 1'b1;
                  end
               end
            end
            StHold: begin
               if (valid_q && op_ready) begin
                  state_d = StFill;
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: state_d = StFill;
         endcase
      end
   end

   // Stale words stay in place until overwritten by the next fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         for (int unsigned k = 0; k < WORDS; k++) begin
            if (fifo_rd_en && (cnt_q == CntW'(k))) begin
               data_q[k*WORD_WIDTH +: WORD_WIDTH] <= fifo_rd_data;
            end
         end
      end
   end

   assign op_valid    = valid_q;
   assign op_data     = data_q;
   assign op_word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: FIFO model, scoreboard of expected operands,
// immediate-assertion checks sampled away from the rising edge.
module tb_fifo_word_packer;

   localparam int unsigned WW = 8;
   localparam int unsigned NW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          fifo_rd_en;
   logic [WW-1:0] fifo_rd_data;
   logic          fifo_rd_empty;
   logic          op_valid;
   logic          op_ready;
   logic [WW*NW-1:0] op_data;
   logic [2:0]    op_word_cnt;

   logic [7:0]  fq[$];
   logic [31:0] sb[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_pops = 0;
   int p0;
   int sz;

   fifo_word_packer #(.WORD_WIDTH(WW), .WORDS(NW)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_empty(fifo_rd_empty),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_data      (op_data),
      .op_word_cnt  (op_word_cnt)
   );

   always #5 clk = ~clk;

   task automatic upd();
      fifo_rd_empty = (fq.size() == 0);
      fifo_rd_data  = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] w);
      fq.push_back(w);
      upd();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One clock: sample before the edge, let the FIFO model pop after it.
   task automatic step();
      logic        pop;
      logic [31:0] e;
      #1;
      chk("rd_en_while_empty", {31'b0, fifo_rd_en & fifo_rd_empty}, 32'd0);
      pop = fifo_rd_en;
      if (op_valid && op_ready && !clr && !rst) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("op_data_xfer", op_data, e);
         end
      end
      @(posedge clk);
      #1;
      if (pop && fq.size() != 0) begin
         void'(fq.pop_front());
         n_pops++;
         upd();
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      op_ready = 1'b0;
      upd();
      #3;
      chk("rst_valid", {31'b0, op_valid}, 32'd0);
      chk("rst_cnt", {29'b0, op_word_cnt}, 32'd0);
      chk("rst_data", op_data, 32'd0);
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // FIFO empty throughout
      op_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("empty_rd_en", {31'b0, fifo_rd_en}, 32'd0);
         chk("empty_cnt", {29'b0, op_word_cnt}, 32'd0);
         chk("empty_valid", {31'b0, op_valid}, 32'd0);
         step();
      end

      // Basic fill, then back-to-back second operand
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      sb.push_back(32'h44332211);
      sb.push_back(32'hA4A3A2A1);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("fill1_rd_en", {31'b0, fifo_rd_en}, 32'd1);
         chk("fill1_cnt", {29'b0, op_word_cnt}, i);
         step();
      end
      chk("fill1_valid", {31'b0, op_valid}, 32'd1);
      chk("fill1_cnt_full", {29'b0, op_word_cnt}, 32'd4);
      chk("hold_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      step();
      chk("after_xfer_valid", {31'b0, op_valid}, 32'd0);
      chk("after_xfer_cnt", {29'b0, op_word_cnt}, 32'd0);
      chk("refill_starts", {31'b0, fifo_rd_en}, 32'd1);
      repeat (4) step();
      chk("fill2_valid", {31'b0, op_valid}, 32'd1);
      step();

      // Gaps between word 1 and word 2
      sb.push_back(32'h04030201);
      push(8'h01);
      #1;
      p0 = n_pops;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("gap_rd_en", {31'b0, fifo_rd_en}, 32'd0);
         chk("gap_cnt", {29'b0, op_word_cnt}, 32'd1);
         step();
      end
      push(8'h02); push(8'h03); push(8'h04);
      step();
      step();
      chk("gap_valid_early", {31'b0, op_valid}, 32'd0);
      step();
      chk("gap_valid_latency", {31'b0, op_valid}, 32'd1);
      chk("gap_pops", n_pops - p0, 32'd4);
      step();
      chk("gap_pops_after", n_pops - p0, 32'd4);

      // Backpressure with 8 words queued
      op_ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      push(8'h55); push(8'h66); push(8'h77); push(8'h88);
      sb.push_back(32'h44332211);
      sb.push_back(32'h88776655);
      repeat (4) step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", {31'b0, op_valid}, 32'd1);
         chk("bp_data", op_data, 32'h44332211);
         chk("bp_rd_en", {31'b0, fifo_rd_en}, 32'd0);
         chk("bp_fifo_count", fq.size(), 32'd4);
         step();
      end
      op_ready = 1'b1;
      step();
      repeat (4) step();
      chk("bp_second_valid", {31'b0, op_valid}, 32'd1);
      step();

      // clr after two words
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
      #1;
      step();
      step();
      chk("clr_pre_cnt", {29'b0, op_word_cnt}, 32'd2);
      clr = 1'b1;
      #1;
      chk("clr_no_pop", {31'b0, fifo_rd_en}, 32'd0);
      sz = fq.size();
      step();
      clr = 1'b0;
      chk("clr_cnt", {29'b0, op_word_cnt}, 32'd0);
      chk("clr_valid", {31'b0, op_valid}, 32'd0);
      chk("clr_fifo_count", fq.size(), sz);
      sb.push_back(32'hC6C5C4C3);
      repeat (4) step();
      chk("clr_refill_valid", {31'b0, op_valid}, 32'd1);
      step();

      // Asynchronous reset mid-fill
      push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); push(8'hD5); push(8'hD6);
      #1;
      step();
      step();
      chk("arst_pre_cnt", {29'b0, op_word_cnt}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'b0, op_valid}, 32'd0);
      chk("arst_cnt", {29'b0, op_word_cnt}, 32'd0);
      chk("arst_data", op_data, 32'd0);
      chk("arst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      step();
      chk("arst_fifo_count", fq.size(), 32'd4);
      rst = 1'b0;
      sb.push_back(32'hD6D5D4D3);
      #1;
      chk("arst_resume_rd_en", {31'b0, fifo_rd_en}, 32'd1);
      repeat (4) step();
      chk("arst_refill_valid", {31'b0, op_valid}, 32'd1);
      step();

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
